// File: rtl/pcecd_adpcm_ram_arb.sv
// pcecd_adpcm_ram_arb: single-port ADPCM RAM arbiter shared by CPU writes/reads,
// CD DMA writes and playback sample fetches. One RAM access at a time, fixed
// priority play > dma > cpu_wr > cpu_rd.
// Optional feature macro: PCECD_ADPCM_HALF_FLAG_EN (registered play_half flag).
module pcecd_adpcm_ram_arb (
    input  logic        clk,
    input  logic        reset,
    input  logic        addr_load,
    input  logic [1:0]  addr_sel,
    input  logic [15:0] addr_in,
    input  logic        cpu_wr_req,
    input  logic [7:0]  cpu_wr_data,
    input  logic        cpu_rd_req,
    output logic [7:0]  cpu_rd_data,
    output logic        cpu_busy,
    input  logic        dma_valid,
    input  logic [7:0]  dma_data,
    output logic        dma_ready,
    input  logic        play_start,
    input  logic        play_req,
    output logic [7:0]  play_data,
    output logic        play_valid,
    output logic        play_end,
    output logic        play_overrun,
    output logic        play_half,
    output logic [15:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_RD   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        GNT_PLAY   = 2'd0,
        GNT_DMA    = 2'd1,
        GNT_CPU_WR = 2'd2,
        GNT_CPU_RD = 2'd3
    } gnt_t;

    state_t      state_q, state_d;
    gnt_t        gnt_q, gnt_d;
    logic        grant_en;
    logic        gnt_is_wr;

    logic [15:0] wr_addr_q, wr_addr_d;
    logic [15:0] rd_addr_q, rd_addr_d;
    logic [15:0] play_addr_q, play_addr_d;
    logic [15:0] play_len_q, play_len_d;

    logic        cpu_wr_pend_q, cpu_wr_pend_d;
    logic [7:0]  cpu_wr_data_q, cpu_wr_data_d;
    logic        cpu_rd_pend_q, cpu_rd_pend_d;
    logic        dma_pend_q, dma_pend_d;
    logic [7:0]  dma_data_q, dma_data_d;
    logic        play_pend_q, play_pend_d;
    logic        play_active_q, play_active_d;
    logic        play_overrun_q, play_overrun_d;

    logic [15:0] ram_addr_q, ram_addr_d;
    logic        ram_we_q, ram_we_d;
    logic [7:0]  ram_wdata_q, ram_wdata_d;
    logic [7:0]  cpu_rd_data_q, cpu_rd_data_d;
    logic [7:0]  play_data_q, play_data_d;
    logic        play_valid_q, play_valid_d;
    logic        play_end_q, play_end_d;

    assign gnt_is_wr = (gnt_q == GNT_DMA) || (gnt_q == GNT_CPU_WR);
    assign cpu_busy  = cpu_wr_pend_q | cpu_rd_pend_q;
    assign dma_ready = ~dma_pend_q;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: IDLE -> ACC on grant; writes finish in ACC, reads go through RD
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (grant_en) state_d = ST_ACC;
            ST_ACC:  state_d = gnt_is_wr ? ST_IDLE : ST_RD;
            ST_RD:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Fixed-priority grant selection, evaluated only while IDLE
    always_comb begin
        gnt_d    = gnt_q;
        grant_en = 1'b0;
        if (state_q == ST_IDLE) begin
            grant_en = 1'b1;
            if (play_pend_q)        gnt_d = GNT_PLAY;
            else if (dma_pend_q)    gnt_d = GNT_DMA;
            else if (cpu_wr_pend_q) gnt_d = GNT_CPU_WR;
            else if (cpu_rd_pend_q) gnt_d = GNT_CPU_RD;
            else                    grant_en = 1'b0;
        end
    end

    // FSM outputs: RAM bus registered at grant, read data captured in RD
    always_comb begin
        ram_addr_d    = ram_addr_q;
        ram_we_d      = 1'b0;
        ram_wdata_d   = ram_wdata_q;
        cpu_rd_data_d = cpu_rd_data_q;
        play_data_d   = play_data_q;
        play_valid_d  = 1'b0;
        play_end_d    = 1'b0;
        if (grant_en) begin
            case (gnt_d)
                GNT_PLAY: ram_addr_d = play_addr_q;
                GNT_DMA: begin
                    ram_addr_d  = wr_addr_q;
                    ram_we_d    = 1'b1;
                    ram_wdata_d = dma_data_q;
                end
                GNT_CPU_WR: begin
                    ram_addr_d  = wr_addr_q;
                    ram_we_d    = 1'b1;
                    ram_wdata_d = cpu_wr_data_q;
                end
                GNT_CPU_RD: ram_addr_d = rd_addr_q;
                default: ;
            endcase
        end
        // Length already decremented at grant; zero here means this fetch is the last
        if (state_q == ST_ACC && gnt_q == GNT_PLAY && play_len_q == '0) begin
            play_end_d = 1'b1;
        end
        if (state_q == ST_RD) begin
            if (gnt_q == GNT_PLAY) begin
                play_data_d  = ram_rdata;
                play_valid_d = 1'b1;
            end else begin
                cpu_rd_data_d = ram_rdata;
            end
        end
    end

    // Request capture into pending flags and playback control
    always_comb begin
        cpu_wr_pend_d  = cpu_wr_pend_q;
        cpu_wr_data_d  = cpu_wr_data_q;
        cpu_rd_pend_d  = cpu_rd_pend_q;
        dma_pend_d     = dma_pend_q;
        dma_data_d     = dma_data_q;
        play_pend_d    = play_pend_q;
        play_active_d  = play_active_q;
        play_overrun_d = play_overrun_q;

        if (!cpu_busy) begin
            if (cpu_wr_req) begin
                cpu_wr_pend_d = 1'b1;
                cpu_wr_data_d = cpu_wr_data;
            end
            if (cpu_rd_req) cpu_rd_pend_d = 1'b1;
        end
        if (dma_valid && dma_ready) begin
            dma_pend_d = 1'b1;
            dma_data_d = dma_data;
        end
        if (play_req && play_active_q) begin
            if (play_pend_q) play_overrun_d = 1'b1;
            else             play_pend_d    = 1'b1;
        end

        if (state_q == ST_ACC) begin
            if (gnt_q == GNT_DMA)    dma_pend_d    = 1'b0;
            if (gnt_q == GNT_CPU_WR) cpu_wr_pend_d = 1'b0;
            if (gnt_q == GNT_PLAY && play_len_q == '0) play_active_d = 1'b0;
        end
        if (state_q == ST_RD) begin
            if (gnt_q == GNT_PLAY) play_pend_d   = 1'b0;
            else                   cpu_rd_pend_d = 1'b0;
        end

        if (play_start && play_len_q != '0) begin
            play_active_d  = 1'b1;
            play_pend_d    = 1'b0;
            play_overrun_d = 1'b0;
        end
    end

    // Address/length counters: step at grant, a load of the same counter wins.
    // The access in flight keeps using ram_addr_q, so a load never disturbs it.
    always_comb begin
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        play_addr_d = play_addr_q;
        play_len_d  = play_len_q;
        if (grant_en) begin
            case (gnt_d)
                GNT_PLAY: begin
                    play_addr_d = play_addr_q + 16'd1;
                    play_len_d  = play_len_q - 16'd1;
                end
                GNT_DMA, GNT_CPU_WR: wr_addr_d = wr_addr_q + 16'd1;
                GNT_CPU_RD:          rd_addr_d = rd_addr_q + 16'd1;
                default: ;
            endcase
        end
        if (addr_load) begin
            case (addr_sel)
                2'd0:    wr_addr_d   = addr_in;
                2'd1:    rd_addr_d   = addr_in;
                2'd2:    play_addr_d = addr_in;
                default: play_len_d  = addr_in;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_q          <= GNT_PLAY;
            wr_addr_q      <= '0;
            rd_addr_q      <= '0;
            play_addr_q    <= '0;
            play_len_q     <= '0;
            cpu_wr_pend_q  <= 1'b0;
            cpu_wr_data_q  <= '0;
            cpu_rd_pend_q  <= 1'b0;
            dma_pend_q     <= 1'b0;
            dma_data_q     <= '0;
            play_pend_q    <= 1'b0;
            play_active_q  <= 1'b0;
            play_overrun_q <= 1'b0;
            ram_addr_q     <= '0;
            ram_we_q       <= 1'b0;
            ram_wdata_q    <= '0;
            cpu_rd_data_q  <= '0;
            play_data_q    <= '0;
            play_valid_q   <= 1'b0;
            play_end_q     <= 1'b0;
        end else begin
            gnt_q          <= gnt_d;
            wr_addr_q      <= wr_addr_d;
            rd_addr_q      <= rd_addr_d;
            play_addr_q    <= play_addr_d;
            play_len_q     <= play_len_d;
            cpu_wr_pend_q  <= cpu_wr_pend_d;
            cpu_wr_data_q  <= cpu_wr_data_d;
            cpu_rd_pend_q  <= cpu_rd_pend_d;
            dma_pend_q     <= dma_pend_d;
            dma_data_q     <= dma_data_d;
            play_pend_q    <= play_pend_d;
            play_active_q  <= play_active_d;
            play_overrun_q <= play_overrun_d;
            ram_addr_q     <= ram_addr_d;
            ram_we_q       <= ram_we_d;
            ram_wdata_q    <= ram_wdata_d;
            cpu_rd_data_q  <= cpu_rd_data_d;
            play_data_q    <= play_data_d;
            play_valid_q   <= play_valid_d;
            play_end_q     <= play_end_d;
        end
    end

`ifdef PCECD_ADPCM_HALF_FLAG_EN
    logic play_half_q, play_half_d;

    // Half-length flag: active playback with less than half the length left
    always_comb begin
        play_half_d = play_active_q & (play_len_q < 16'h8000);
    end

    // Half-length flag register
    always_ff @(posedge clk) begin
        if (reset) begin
            play_half_q <= 1'b0;
        end else begin
            play_half_q <= play_half_d;
        end
    end

    assign play_half = play_half_q;
`else
    assign play_half = 1'b0;
`endif

    assign cpu_rd_data  = cpu_rd_data_q;
    assign play_data    = play_data_q;
    assign play_valid   = play_valid_q;
    assign play_end     = play_end_q;
    assign play_overrun = play_overrun_q;
    assign ram_addr     = ram_addr_q;
    assign ram_we       = ram_we_q;
    assign ram_wdata    = ram_wdata_q;

endmodule

// File: tb/tb_pcecd_adpcm_ram_arb.sv
// tb_pcecd_adpcm_ram_arb: directed scenarios plus randomized request mixes for
// pcecd_adpcm_ram_arb, checked against a transaction-level model (priority-ordered
// RAM effects, counters as plain integers, reference memory image).
`timescale 1ns/1ps
module tb_pcecd_adpcm_ram_arb;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        addr_load = 1'b0;
    logic [1:0]  addr_sel = '0;
    logic [15:0] addr_in = '0;
    logic        cpu_wr_req = 1'b0;
    logic [7:0]  cpu_wr_data = '0;
    logic        cpu_rd_req = 1'b0;
    logic [7:0]  cpu_rd_data;
    logic        cpu_busy;
    logic        dma_valid = 1'b0;
    logic [7:0]  dma_data = '0;
    logic        dma_ready;
    logic        play_start = 1'b0;
    logic        play_req = 1'b0;
    logic [7:0]  play_data;
    logic        play_valid;
    logic        play_end;
    logic        play_overrun;
    logic        play_half;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = '0;

    pcecd_adpcm_ram_arb dut (
        .clk(clk), .reset(reset),
        .addr_load(addr_load), .addr_sel(addr_sel), .addr_in(addr_in),
        .cpu_wr_req(cpu_wr_req), .cpu_wr_data(cpu_wr_data),
        .cpu_rd_req(cpu_rd_req), .cpu_rd_data(cpu_rd_data), .cpu_busy(cpu_busy),
        .dma_valid(dma_valid), .dma_data(dma_data), .dma_ready(dma_ready),
        .play_start(play_start), .play_req(play_req), .play_data(play_data),
        .play_valid(play_valid), .play_end(play_end), .play_overrun(play_overrun),
        .play_half(play_half),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM attached to the DUT: one-cycle read latency
    logic [7:0] ram [0:65535];
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    typedef struct { logic [15:0] a; logic [7:0] d; int c; } wr_ev_t;
    typedef struct { logic [7:0] d; int c; logic rdy; } pv_ev_t;

    wr_ev_t wq[$];
    pv_ev_t pq[$];
    int     cyc = 0;
    int     end_cnt = 0;

    // Bus monitor, sampled on the falling edge
    always @(negedge clk) begin
        wr_ev_t w;
        pv_ev_t p;
        cyc = cyc + 1;
        if (ram_we) begin
            w.a = ram_addr; w.d = ram_wdata; w.c = cyc;
            wq.push_back(w);
        end
        if (play_valid) begin
            p.d = play_data; p.c = cyc; p.rdy = dma_ready;
            pq.push_back(p);
        end
        if (play_end) end_cnt = end_cnt + 1;
    end

    // Reference model state
    logic [7:0]  ref_mem [0:65535];
    logic [15:0] m_waddr, m_raddr, m_paddr, m_len;
    logic        m_active, m_ovr;
    int          m_ends;

    int n_tests = 0;
    int n_fail  = 0;

    int op_pv_cyc;
    logic op_pv_rdy;
    int op_wr_cyc[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_half();
`ifdef PCECD_ADPCM_HALF_FLAG_EN
        return m_active && (m_len < 16'h8000);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_waddr = '0; m_raddr = '0; m_paddr = '0; m_len = '0;
        m_active = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic load_ctr(input logic [1:0] sel, input logic [15:0] val);
        addr_load = 1'b1; addr_sel = sel; addr_in = val;
        tick();
        addr_load = 1'b0;
        case (sel)
            2'd0:    m_waddr = val;
            2'd1:    m_raddr = val;
            2'd2:    m_paddr = val;
            default: m_len   = val;
        endcase
    endtask

    task automatic start_play();
        play_start = 1'b1;
        tick();
        play_start = 1'b0;
        if (m_len != 16'h0) begin
            m_active = 1'b1;
            m_ovr    = 1'b0;
        end
    endtask

    // One burst of same-cycle requests; p2 repeats play_req on the next cycle.
    task automatic run_op(input bit p, input bit p2, input bit d, input bit w, input bit r,
                          input logic [7:0] dd, input logic [7:0] wd);
        wr_ev_t     exp_w[$];
        logic [7:0] exp_p[$];
        logic [7:0] exp_rd;
        wr_ev_t     ev;
        pv_ev_t     pe;
        int         n;
        exp_rd = '0;
        // RAM effects in grant-priority order: play, dma, cpu write, cpu read
        if (p && m_active) begin
            if (p2) m_ovr = 1'b1;
            exp_p.push_back(ref_mem[m_paddr]);
            m_paddr = m_paddr + 16'd1;
            m_len   = m_len - 16'd1;
            if (m_len == 16'h0) begin
                m_active = 1'b0;
                m_ends++;
            end
        end
        if (d) begin
            ev.a = m_waddr; ev.d = dd; ev.c = 0;
            exp_w.push_back(ev);
            ref_mem[m_waddr] = dd;
            m_waddr = m_waddr + 16'd1;
        end
        if (w) begin
            ev.a = m_waddr; ev.d = wd; ev.c = 0;
            exp_w.push_back(ev);
            ref_mem[m_waddr] = wd;
            m_waddr = m_waddr + 16'd1;
        end
        if (r) begin
            exp_rd  = ref_mem[m_raddr];
            m_raddr = m_raddr + 16'd1;
        end

        play_req = p; dma_valid = d; dma_data = dd;
        cpu_wr_req = w; cpu_wr_data = wd; cpu_rd_req = r;
        tick();
        dma_valid = 1'b0; cpu_wr_req = 1'b0; cpu_rd_req = 1'b0;
        play_req = p2;
        tick();
        play_req = 1'b0;
        repeat (16) tick();

        check_eq("wr_count", 32'(wq.size()), 32'(exp_w.size()));
        n = (wq.size() < exp_w.size()) ? wq.size() : exp_w.size();
        op_wr_cyc.delete();
        for (int i = 0; i < n; i++) begin
            ev = wq.pop_front();
            op_wr_cyc.push_back(ev.c);
            check_eq("wr_addr", 32'(ev.a), 32'(exp_w[i].a));
            check_eq("wr_data", 32'(ev.d), 32'(exp_w[i].d));
        end
        wq.delete();

        check_eq("play_count", 32'(pq.size()), 32'(exp_p.size()));
        n = (pq.size() < exp_p.size()) ? pq.size() : exp_p.size();
        op_pv_cyc = -1;
        op_pv_rdy = 1'b1;
        for (int i = 0; i < n; i++) begin
            pe = pq.pop_front();
            if (i == 0) begin
                op_pv_cyc = pe.c;
                op_pv_rdy = pe.rdy;
            end
            check_eq("play_data", 32'(pe.d), 32'(exp_p[i]));
        end
        pq.delete();

        if (r) check_eq("cpu_rd_data", 32'(cpu_rd_data), 32'(exp_rd));
        check_eq("play_end_count", 32'(end_cnt), 32'(m_ends));
        check_eq("play_overrun", 32'(play_overrun), 32'(m_ovr));
        check_eq("play_half", 32'(play_half), 32'(exp_half()));
        check_eq("cpu_busy_idle", 32'(cpu_busy), 32'd0);
        check_eq("dma_ready_idle", 32'(dma_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] v;
        bit found;
        for (int i = 0; i < 65536; i++) begin
            v = 8'($urandom);
            if (i == 16'hFFFF) v = 8'h11;
            if (i == 0)        v = 8'h22;
            ram[i] <= v;
            ref_mem[i] = v;
        end
        m_ends = 0;
        model_reset();

        // Reset values
        reset = 1'b1;
        repeat (3) tick();
        check_eq("rst_cpu_rd_data", 32'(cpu_rd_data), 32'd0);
        check_eq("rst_play_data", 32'(play_data), 32'd0);
        check_eq("rst_play_valid", 32'(play_valid), 32'd0);
        check_eq("rst_play_end", 32'(play_end), 32'd0);
        check_eq("rst_play_half", 32'(play_half), 32'd0);
        check_eq("rst_ram_addr", 32'(ram_addr), 32'd0);
        check_eq("rst_ram_we", 32'(ram_we), 32'd0);
        check_eq("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        check_eq("rst_cpu_busy", 32'(cpu_busy), 32'd0);
        check_eq("rst_dma_ready", 32'(dma_ready), 32'd1);
        reset = 1'b0;
        tick();
        wq.delete(); pq.delete(); end_cnt = 0;

        // play_start with zero length is ignored: no fetch follows
        start_play();
        run_op(1, 0, 0, 0, 0, 8'h00, 8'h00);

        // Playback wrap across 0xFFFF, ending after two fetches
        load_ctr(2'd2, 16'hFFFF);
        load_ctr(2'd3, 16'd2);
        start_play();
        run_op(1, 0, 0, 0, 0, 8'h00, 8'h00);
        check_eq("wrap_data0", 32'(play_data), 32'h11);
        run_op(1, 0, 0, 0, 0, 8'h00, 8'h00);
        check_eq("wrap_data1", 32'(play_data), 32'h22);
        check_eq("wrap_end", 32'(end_cnt), 32'd1);
        run_op(1, 0, 0, 0, 0, 8'h00, 8'h00);

        // CPU write then read back at the same address
        load_ctr(2'd0, 16'h1234);
        run_op(0, 0, 0, 1, 0, 8'h00, 8'hA5);
        load_ctr(2'd1, 16'h1234);
        run_op(0, 0, 0, 0, 1, 8'h00, 8'h00);
        check_eq("cpu_rd_back", 32'(cpu_rd_data), 32'hA5);
        run_op(0, 0, 1, 0, 1, 8'h77, 8'h00);
        check_eq("post_inc_rd", 32'(cpu_rd_data), 32'h77);

        // Priority: play, then dma, then cpu write, all requested together
        load_ctr(2'd2, 16'h0100);
        load_ctr(2'd3, 16'h0010);
        start_play();
        run_op(1, 0, 1, 1, 0, 8'h3C, 8'hC3);
        check_eq("prio_order", 32'((op_wr_cyc.size() == 2) && (op_pv_cyc >= 0) &&
                 (op_pv_cyc < op_wr_cyc[0]) && (op_wr_cyc[0] < op_wr_cyc[1])), 32'd1);
        check_eq("prio_dma_ready_low", 32'(op_pv_rdy), 32'd0);

        // Overrun: second tick while the first fetch is pending
        run_op(1, 1, 0, 0, 0, 8'h00, 8'h00);
        check_eq("overrun_set", 32'(play_overrun), 32'd1);
        start_play();
        run_op(0, 0, 0, 0, 0, 8'h00, 8'h00);

        // Half flag: 0x8001 less one fetch is 0x8000 (not below half), next fetch is
        load_ctr(2'd3, 16'h8001);
        start_play();
        run_op(1, 0, 0, 0, 0, 8'h00, 8'h00);
        run_op(1, 0, 0, 0, 0, 8'h00, 8'h00);

        // Reset while a DMA write is in its access cycle, CPU write still queued
        dma_valid = 1'b1; dma_data = 8'h5A;
        cpu_wr_req = 1'b1; cpu_wr_data = 8'h99;
        tick();
        dma_valid = 1'b0; cpu_wr_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (ram_we) found = 1'b1;
            else tick();
        end
        check_eq("rst_mid_acc_reached", 32'(found), 32'd1);
        reset = 1'b1;
        tick();
        check_eq("rst_mid_ram_we", 32'(ram_we), 32'd0);
        check_eq("rst_mid_dma_ready", 32'(dma_ready), 32'd1);
        check_eq("rst_mid_cpu_busy", 32'(cpu_busy), 32'd0);
        check_eq("rst_mid_overrun", 32'(play_overrun), 32'd0);
        reset = 1'b0;
        // The write enable was still high on the reset edge, so that byte landed
        if (found) ref_mem[m_waddr] = 8'h5A;
        model_reset();
        tick();
        wq.delete(); pq.delete(); end_cnt = 0; m_ends = 0;

        // Randomized request mixes
        for (int it = 0; it < 120; it++) begin
            case ($urandom_range(0, 9))
                0: load_ctr(2'd0, ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom));
                1: load_ctr(2'd1, 16'($urandom));
                2: load_ctr(2'd2, ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom));
                3: load_ctr(2'd3, 16'($urandom_range(1, 6)));
                4: start_play();
                default: ;
            endcase
            begin
                bit p, p2;
                p  = 1'($urandom);
                p2 = p && ($urandom_range(0, 7) == 0);
                run_op(p, p2, 1'($urandom), 1'($urandom), 1'($urandom),
                       8'($urandom), 8'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
